// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port, decode handshake and execute redirect.
interface fetch_unit_if #(
  parameter int unsigned addr_size = 16,
  parameter int unsigned data_size = 16
);
  logic                 mem_req;
  logic [addr_size-1:0] mem_addr;
  logic                 mem_ack;
  logic [data_size-1:0] mem_data;
  logic                 instr_valid;
  logic [data_size-1:0] instr;
  logic [addr_size-1:0] instr_ip;
  logic                 instr_ready;
  logic                 do_jmp;
  logic [addr_size-1:0] jaddr;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_ip,
    input  mem_ack, mem_data, instr_ready, do_jmp, jaddr
  );
  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_ip,
    output mem_ack, mem_data, instr_ready, do_jmp, jaddr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: single-outstanding reads into a small buffer feeding decode.
// FETCH_PREFETCH_EN selects a two-entry buffer (one word of lookahead); default is one entry.
module fetch_unit #(
  parameter int unsigned          addr_size  = 16,
  parameter int unsigned          data_size  = 16,
  parameter logic [addr_size-1:0] reset_addr = '0
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
`ifdef FETCH_PREFETCH_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  typedef enum logic [1:0] {FETCH, WAIT, FLUSH} state_t;

  state_t                         state;
  logic [addr_size-1:0]           ip, target, flush_tgt;
  logic [D-1:0][data_size-1:0]    buf_word, word_nxt;
  logic [D-1:0][addr_size-1:0]    buf_addr, addr_nxt;
  logic [1:0]                     count, count_nxt, wr_idx;
  logic                           pop, push, room;

  assign bus.instr_valid = (count != 2'd0);
  assign bus.instr       = buf_word[0];
  assign bus.instr_ip    = buf_addr[0];

  // A redirect kills both sides of the buffer in the cycle it arrives.
  assign pop       = bus.instr_valid && bus.instr_ready && !bus.do_jmp;
  assign push      = (state == WAIT) && bus.mem_ack && !bus.do_jmp;
  assign count_nxt = count - 2'(pop) + 2'(push);
  assign wr_idx    = count - 2'(pop);
  assign room      = (count_nxt < 2'(D));
  assign flush_tgt = bus.do_jmp ? bus.jaddr : target;

  always_comb begin
    word_nxt = buf_word;
    addr_nxt = buf_addr;
    if (pop)
      for (int i = 0; i < D - 1; i++) begin
        word_nxt[i] = buf_word[i+1];
        addr_nxt[i] = buf_addr[i+1];
      end
    if (push)
      for (int i = 0; i < D; i++)
        if (wr_idx == 2'(i)) begin
          word_nxt[i] = bus.mem_data;
          addr_nxt[i] = ip;
        end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_word <= '0;
      buf_addr <= '0;
      count    <= 2'd0;
    end else begin
      buf_word <= word_nxt;
      buf_addr <= addr_nxt;
      count    <= bus.do_jmp ? 2'd0 : count_nxt;
    end
  end

  // ip always equals the address of the outstanding request while in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      ip           <= reset_addr;
      target       <= reset_addr;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= reset_addr;
    end else begin
      case (state)
        FETCH: begin
          if (bus.do_jmp) begin
            ip           <= bus.jaddr;
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= bus.jaddr;
            state        <= WAIT;
          end else if (room) begin
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= ip;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_ack) begin
            if (bus.do_jmp) begin
              ip           <= bus.jaddr;
              bus.mem_addr <= bus.jaddr;
            end else if (room) begin
              ip           <= ip + addr_size'(1);
              bus.mem_addr <= ip + addr_size'(1);
            end else begin
              ip           <= ip + addr_size'(1);
              bus.mem_req  <= 1'b0;
              state        <= FETCH;
            end
          end else if (bus.do_jmp) begin
            target <= bus.jaddr;
            state  <= FLUSH;
          end
        end
        FLUSH: begin
          if (bus.mem_ack) begin
            ip           <= flush_tgt;
            bus.mem_addr <= flush_tgt;
            state        <= WAIT;
          end else if (bus.do_jmp) begin
            target <= bus.jaddr;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: randomized memory latency / decode stalls / redirects vs a stream model.
module tb_fetch_unit;
  localparam logic [15:0] RST_ADDR = 16'h0100;
`ifdef FETCH_PREFETCH_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fetch_unit_if #(.addr_size(16), .data_size(16)) bus();

  fetch_unit #(.addr_size(16), .data_size(16), .reset_addr(RST_ADDR)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // memory model
  bit          pend;
  logic [15:0] paddr;
  int          pwait, cur_lat, lat_lo, lat_hi, unstable;
  bit          stall_en;
  logic [15:0] stall_addr;
  int          stall_lat;
  logic [15:0] ack_q[$];

  // ordered log of decode-side events: redirects and pops
  bit          ev_jmp[$];
  logic [15:0] ev_addr[$];
  logic [15:0] ev_word[$];
  int          bad_idx;
  logic [15:0] bad_exp;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  // Reference: decode sees consecutive addresses from start, restarting at each redirect target.
  function automatic int model_bad(input logic [15:0] start, output int npop);
    logic [15:0] exp;
    int bad;
    exp = start; bad = 0; npop = 0;
    for (int i = 0; i < ev_jmp.size(); i++) begin
      if (ev_jmp[i]) exp = ev_addr[i];
      else begin
        npop++;
        if (ev_addr[i] !== exp || ev_word[i] !== mem_word(exp)) begin
          bad++;
          if (bad == 1) begin bad_idx = i; bad_exp = exp; end
        end
        exp = exp + 16'd1;
      end
    end
    return bad;
  endfunction

  task automatic step(input bit rdy, input bit jmp, input logic [15:0] ja);
    @(negedge clk);
    bus.instr_ready = rdy;
    bus.do_jmp      = jmp;
    bus.jaddr       = ja;
    bus.mem_ack     = 1'b0;
    if (bus.mem_req) begin
      if (!pend) begin
        pend = 1'b1; paddr = bus.mem_addr; pwait = 0;
        if (stall_en && paddr == stall_addr) begin cur_lat = stall_lat; stall_en = 1'b0; end
        else cur_lat = int'($urandom_range(lat_hi, lat_lo));
      end else if (bus.mem_addr !== paddr) unstable++;
      if (pwait >= cur_lat) begin
        bus.mem_ack = 1'b1; bus.mem_data = mem_word(paddr);
        ack_q.push_back(paddr); pend = 1'b0;
      end else pwait++;
    end
    if (jmp) begin
      ev_jmp.push_back(1'b1); ev_addr.push_back(ja); ev_word.push_back(16'h0);
    end else if (bus.instr_valid && rdy) begin
      ev_jmp.push_back(1'b0); ev_addr.push_back(bus.instr_ip); ev_word.push_back(bus.instr);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_data = 16'h0; bus.instr_ready = 1'b0;
    bus.do_jmp = 1'b0; bus.jaddr = 16'h0;
    pend = 1'b0; stall_en = 1'b0; lat_lo = 0; lat_hi = 0; unstable = 0;
    repeat (2) @(negedge clk);
    ack_q.delete(); ev_jmp.delete(); ev_addr.delete(); ev_word.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req); end
    checks++; if (bus.mem_addr !== RST_ADDR) begin errors++; $display("FAIL reset_mem_addr got %h want %h", bus.mem_addr, RST_ADDR); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %b want 0", bus.instr_valid); end
    checks++; if (bus.instr !== 16'h0 || bus.instr_ip !== 16'h0) begin errors++; $display("FAIL reset_instr got %h/%h want 0000/0000", bus.instr, bus.instr_ip); end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 16'h0);
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== RST_ADDR) begin errors++; $display("FAIL first_req got %b@%h want 1@%h", bus.mem_req, bus.mem_addr, RST_ADDR); end
  endtask

  task automatic test_stream();
    int n0, np, nb;
    do_reset();
    repeat (14) step(1'b1, 1'b0, 16'h0);
    n0 = ev_jmp.size();
    repeat (10) step(1'b1, 1'b0, 16'h0);
    checks++; if (ev_jmp.size() - n0 !== (D == 2 ? 10 : 5)) begin errors++; $display("FAIL stream_rate got %0d want %0d pops in 10 cycles", ev_jmp.size() - n0, (D == 2 ? 10 : 5)); end
    nb = model_bad(RST_ADDR, np);
    checks++; if (nb !== 0 || np < 10) begin errors++; $display("FAIL stream_order got %0d bad of %0d pops (first ev %0d want %h)", nb, np, bad_idx, bad_exp); end
  endtask

  task automatic test_stall();
    int np, nb;
    do_reset();
    repeat (10) step(1'b0, 1'b0, 16'h0);
    checks++; if (ack_q.size() !== D) begin errors++; $display("FAIL stall_req_count got %0d want %0d", ack_q.size(), D); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL stall_req_idle got %b want 0", bus.mem_req); end
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_ip !== RST_ADDR) begin errors++; $display("FAIL stall_head got %b@%h want 1@%h", bus.instr_valid, bus.instr_ip, RST_ADDR); end
    repeat (10) step(1'b1, 1'b0, 16'h0);
    checks++; if (ack_q.size() <= D || ack_q[D] !== RST_ADDR + 16'(D)) begin errors++; $display("FAIL stall_resume got %h want %h", (ack_q.size() > D) ? ack_q[D] : 16'hxxxx, RST_ADDR + 16'(D)); end
    nb = model_bad(RST_ADDR, np);
    checks++; if (nb !== 0) begin errors++; $display("FAIL stall_order got %0d bad (first ev %0d want %h)", nb, bad_idx, bad_exp); end
  endtask

  task automatic test_redirect_flush(input bit twice);
    int k, n0, np, nb, idx;
    logic [15:0] tgt;
    do_reset();
    stall_en = 1'b1; stall_addr = 16'h0105; stall_lat = twice ? 4 : 3;
    tgt = twice ? 16'h4000 : 16'h2000;
    k = 0;
    do begin step(1'b1, 1'b0, 16'h0); k++; end
    while (!(bus.mem_req && bus.mem_addr == 16'h0105 && pend) && k < 60);
    checks++; if (k >= 60) begin errors++; $display("FAIL flush_setup got timeout want request to 0105"); end
    step(1'b1, 1'b1, twice ? 16'h3000 : 16'h2000);
    if (twice) step(1'b1, 1'b1, 16'h4000);
    n0 = ack_q.size();
    step(1'b1, 1'b0, 16'h0);
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", bus.instr_valid); end
    k = 0;
    while (ack_q.size() == n0 && k < 20) begin step(1'b1, 1'b0, 16'h0); k++; end
    step(1'b1, 1'b0, 16'h0);
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== tgt) begin errors++; $display("FAIL flush_target_req got %b@%h want 1@%h", bus.mem_req, bus.mem_addr, tgt); end
    repeat (8) step(1'b1, 1'b0, 16'h0);
    idx = -1;
    for (int i = 0; i < ack_q.size(); i++) if (idx < 0 && ack_q[i] == 16'h0105) idx = i;
    checks++; if (idx < 0 || idx + 1 >= ack_q.size() || ack_q[idx+1] !== tgt) begin errors++; $display("FAIL flush_next_addr got idx %0d want %h after 0105", idx, tgt); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL flush_addr_stable got %0d changes want 0", unstable); end
    nb = model_bad(RST_ADDR, np);
    checks++; if (nb !== 0) begin errors++; $display("FAIL flush_order got %0d bad (first ev %0d want %h)", nb, bad_idx, bad_exp); end
  endtask

  task automatic test_jmp_ack();
    int k, n_ack, np, nb;
    do_reset();
    repeat (6) step(1'b1, 1'b0, 16'h0);
    k = 0;
    forever begin
      @(posedge clk); #1;
      if ((bus.mem_req && (D == 1 || bus.instr_valid)) || k >= 10) break;
      step(1'b1, 1'b0, 16'h0); k++;
    end
    n_ack = ack_q.size();
    step(1'b1, 1'b1, 16'h6000);
    checks++; if (ack_q.size() !== n_ack + 1) begin errors++; $display("FAIL jmpack_coincide got %0d acks want %0d", ack_q.size() - n_ack, 1); end
    @(posedge clk); #1;
    checks++; if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h6000) begin errors++; $display("FAIL jmpack_next got v%b r%b@%h want v0 r1@6000", bus.instr_valid, bus.mem_req, bus.mem_addr); end
    repeat (8) step(1'b1, 1'b0, 16'h0);
    nb = model_bad(RST_ADDR, np);
    checks++; if (nb !== 0) begin errors++; $display("FAIL jmpack_order got %0d bad (first ev %0d want %h)", nb, bad_idx, bad_exp); end
  endtask

  task automatic test_wrap();
    int idx, np, nb;
    do_reset();
    step(1'b1, 1'b1, 16'hFFFE);
    repeat (12) step(1'b1, 1'b0, 16'h0);
    idx = -1;
    for (int i = 0; i < ack_q.size(); i++) if (idx < 0 && ack_q[i] == 16'hFFFE) idx = i;
    checks++; if (idx < 0 || idx + 2 >= ack_q.size() || ack_q[idx+1] !== 16'hFFFF || ack_q[idx+2] !== 16'h0000) begin errors++; $display("FAIL wrap_addr got idx %0d want FFFE FFFF 0000", idx); end
    nb = model_bad(RST_ADDR, np);
    checks++; if (nb !== 0 || np < 3) begin errors++; $display("FAIL wrap_order got %0d bad of %0d pops (first ev %0d want %h)", nb, np, bad_idx, bad_exp); end
  endtask

  task automatic test_random();
    int np, nb;
    do_reset();
    lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 1500; i++)
      step($urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0, 16'($urandom));
    nb = model_bad(RST_ADDR, np);
    checks++; if (nb !== 0 || np < 100) begin errors++; $display("FAIL random_order got %0d bad of %0d pops (first ev %0d want %h)", nb, np, bad_idx, bad_exp); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL random_addr_stable got %0d changes want 0", unstable); end
  endtask

  task automatic test_async_reset();
    do_reset();
    stall_en = 1'b1; stall_addr = RST_ADDR; stall_lat = 10;
    step(1'b1, 1'b0, 16'h0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== RST_ADDR) begin errors++; $display("FAIL async_reset got %b@%h want 0@%h", bus.mem_req, bus.mem_addr, RST_ADDR); end
    pend = 1'b0; stall_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.mem_ack = 1'b0; bus.mem_data = 16'h0; bus.instr_ready = 1'b0;
    bus.do_jmp = 1'b0; bus.jaddr = 16'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush(1'b0);
    test_redirect_flush(1'b1);
    test_jmp_ack();
    test_wrap();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
